uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per UART bit period (legal range 4..65535).
REQ-002 Parameter RX_SYNC_STAGES, default 2, flip-flop stages in the rx_i input synchroniser (minimum 2).
REQ-003 Port clk_i  input  1  sole clock; all flops on rising edge.
REQ-004 Port arstn_i  input  1  asynchronous, active-low reset (driven from the reset synchroniser).
REQ-005 Port rx_i  input  1  asynchronous serial line; idle high; 8N1 framing (8E1 with REQ-023).
REQ-006 Port ready_i  input  1  consumer accepts data_o when high with valid_o high.
REQ-007 Port data_o  output  8  received byte, LSB received first.
REQ-008 Port valid_o  output  1  data_o holds an unconsumed byte.
REQ-009 Port frame_err_o  output  1  stop bit of the byte on data_o was sampled low.
REQ-010 Port overrun_o  output  1  one-cycle pulse: a completed byte was dropped.

Function
REQ-011 rx_i SHALL pass through RX_SYNC_STAGES flops, reset to 1, before any use; the last stage is "rxs".
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY per REQ-023).
- IDLE: a falling edge of rxs (previous 1, current 0) -> START and clears the bit counter.
- START: at count CLKS_PER_BIT/2 (integer division) samples rxs; 1 -> IDLE (glitch, no output); 0 -> DATA.
- DATA: samples rxs every CLKS_PER_BIT cycles, 8 samples, shifted LSB-first; after the 8th -> STOP.
- STOP: samples rxs after CLKS_PER_BIT cycles; the result is sampled stop = 1 -> frame_err = 0, 0 -> frame_err = 1; -> IDLE.
REQ-013 The cycle counter SHALL be 16 bits wide, SHALL reload to 0 on every sample, and SHALL NOT wrap within a bit.
REQ-014 A line held low through STOP (break) SHALL NOT start a new frame until rxs returns high, because IDLE requires a falling edge.
REQ-015 On the STOP sample, the byte and frame_err SHALL be loaded into data_o and frame_err_o, and valid_o SHALL be set; these are visible the next cycle, one cycle after the stop sample.
REQ-016 valid_o, data_o and frame_err_o SHALL hold stable until a cycle with valid_o=1 and ready_i=1; valid_o clears the next cycle unless REQ-017 applies.
REQ-017 If a byte completes in the same cycle as acceptance (valid_o=1, ready_i=1), the new byte SHALL load and valid_o SHALL stay high.
REQ-018 If a byte completes while valid_o=1 and ready_i=0:
- the new byte is discarded;
- data_o keeps the old value;
- overrun_o pulses high for exactly one cycle.
REQ-019 A frame with a framing error SHALL still be delivered; the receiver SHALL NOT stall.

Reset
REQ-020 With arstn_i low, all outputs SHALL be 0 asynchronously: data_o = 0x00, valid_o = 0, frame_err_o = 0, overrun_o = 0.
REQ-021 With arstn_i low, the FSM SHALL be in IDLE, counters SHALL be 0, and synchroniser flops SHALL be 1.
REQ-022 Reset asserted mid-frame SHALL abandon the partial byte; after release, the next valid frame SHALL be received correctly.

Configuration
REQ-023 With macro UART_RX_PARITY_EN defined:
- a PARITY state sits between DATA and STOP and samples one even-parity bit;
- output parity_err_o (1 bit, reset 0) is added;
- parity_err_o is loaded and held alongside data_o, and is 1 when the XOR of the 8 data bits and the parity bit is 1.
Without the macro, there is no PARITY state and no parity_err_o port.

Verification (CLKS_PER_BIT=16)
REQ-024 Send 0xA5 with a valid stop, ready_i=1 -> data_o=0xA5, valid_o high for 1 cycle, 1 cycle after the stop sample; frame_err_o=0.
REQ-025 Drive rx_i low for 4 cycles in idle -> no valid_o; FSM returns to IDLE; a subsequent 0x5A is received correctly.
REQ-026 Send 0x3C with the stop bit low -> data_o=0x3C, frame_err_o=1; line held low 40 cycles then high -> no further byte.
REQ-027 Send 0x01 then 0x02 back-to-back with ready_i=0 -> data_o=0x01 held, overrun_o one-cycle pulse at the 0x02 stop; ready_i=1 -> valid_o clears.
REQ-028 Assert arstn_i at data bit 4 of 0xFF -> all outputs 0 immediately; after release, 0x81 is received correctly.
REQ-029 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err_o=1; with parity bit 1 -> parity_err_o=0.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling-by-count UART receiver (8N1) with a ready/valid byte output.
// Define UART_RX_PARITY_EN for 8E1 framing and the parity_err_o output.
module uart_rx #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int RX_SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       rx_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err_o,
`endif
    output logic       overrun_o
);
    localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] FULL = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_q;
    logic [RX_SYNC_STAGES-1:0] sync_q;
    logic                      rxs_prev_q;
    logic [15:0]               cnt_q;
    logic [2:0]                bit_q;
    logic [7:0]                shift_q;
    logic [7:0]                data_q;
    logic                      valid_q;
    logic                      fe_q;
    logic                      overrun_q;
    logic                      rxs;
    logic                      hit_d;
    logic                      pe_d;
`ifdef UART_RX_PARITY_EN
    logic                      par_q;
    logic                      pe_q;
    assign pe_d         = ^{shift_q, par_q};
    assign parity_err_o = pe_q;
`else
    assign pe_d = 1'b0;
`endif

    assign rxs         = sync_q[RX_SYNC_STAGES-1];
    assign hit_d       = cnt_q == FULL;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = overrun_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q    <= IDLE;
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            fe_q       <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            sync_q     <= {sync_q[RX_SYNC_STAGES-2:0], rx_i};
            rxs_prev_q <= rxs;
            overrun_q  <= 1'b0;
            if (valid_q && ready_i) valid_q <= 1'b0;
            case (state_q)
                IDLE: if (rxs_prev_q && !rxs) begin
                    state_q <= START;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                end
                START: if (cnt_q == HALF) begin
                    cnt_q   <= '0;
                    state_q <= rxs ? IDLE : DATA;
                end else cnt_q <= cnt_q + 16'd1;
                DATA: if (hit_d) begin
                    cnt_q   <= '0;
                    shift_q <= {rxs, shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_q == 3'd7) state_q <= PARITY;
`else
                    if (bit_q == 3'd7) state_q <= STOP;
`endif
                end else cnt_q <= cnt_q + 16'd1;
`ifdef UART_RX_PARITY_EN
                PARITY: if (hit_d) begin
                    cnt_q   <= '0;
                    par_q   <= rxs;
                    state_q <= STOP;
                end else cnt_q <= cnt_q + 16'd1;
`endif
                STOP: if (hit_d) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    // A full output slot that is not being drained this cycle drops the new byte.
                    if (!valid_q || ready_i) begin
                        data_q  <= shift_q;
                        fe_q    <= !rxs;
                        valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        pe_q    <= pe_d;
`endif
                    end else overrun_q <= 1'b1;
                end else cnt_q <= cnt_q + 16'd1;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    logic unused_pe;
    assign unused_pe = pe_d;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;
    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk_i   = 1'b0;
    logic       arstn_i = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b1;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       pe_w;
    int         checks     = 0;
    int         errors     = 0;
    int         vcycles    = 0;
    int         ovr_cycles = 0;
    logic [9:0] obs_q[$];

`ifdef UART_RX_PARITY_EN
    logic parity_err_o;
    assign pe_w = parity_err_o;
`else
    assign pe_w = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    uart_rx #(.CLKS_PER_BIT(CPB), .RX_SYNC_STAGES(2)) dut (
        .clk_i       (clk_i),
        .arstn_i     (arstn_i),
        .rx_i        (rx_i),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .frame_err_o (frame_err_o),
`ifdef UART_RX_PARITY_EN
        .parity_err_o(parity_err_o),
`endif
        .overrun_o   (overrun_o)
    );

    // Every accepted byte is logged as {parity_err, frame_err, data}.
    always @(negedge clk_i) begin
        if (valid_o) vcycles++;
        if (overrun_o) ovr_cycles++;
        if (valid_o && ready_i) obs_q.push_back({pe_w, frame_err_o, data_o});
    end

    function automatic logic [9:0] expect_word(input logic [7:0] d, input logic stop_b, input logic par_b);
        logic pe;
        pe = PAR_EN && ((($countones(d) + int'(par_b)) % 2) == 1);
        return {pe, !stop_b, d};
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        rx_i = b;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (PAR_EN) drive_bit(par_b);
        drive_bit(stop_b);
    endtask

    task automatic test_reset;
        arstn_i = 1'b0;
        cycles(3);
        checks += 4;
        if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_o); end
        if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
        if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", frame_err_o); end
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun_o); end
        arstn_i = 1'b1;
        cycles(4);
    endtask

    task automatic test_basic;
        int v0;
        logic [9:0] got;
        ready_i = 1'b1;
        obs_q.delete();
        v0 = vcycles;
        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        cycles(8);
        checks += 2;
        if (vcycles - v0 != 1) begin errors++; $display("FAIL basic_pulse: got %0d valid cycles expected 1", vcycles - v0); end
        if (obs_q.size() != 1) begin errors++; $display("FAIL basic_count: got %0d bytes expected 1", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            checks++;
            if (got !== expect_word(8'hA5, 1'b1, even_par(8'hA5)))
                begin errors++; $display("FAIL basic_data: got %h expected %h", got, expect_word(8'hA5, 1'b1, even_par(8'hA5))); end
        end
    endtask

    task automatic test_glitch;
        int v0;
        logic [9:0] got;
        obs_q.delete();
        v0 = vcycles;
        rx_i = 1'b0;
        cycles(4);
        rx_i = 1'b1;
        cycles(40);
        checks += 2;
        if (vcycles != v0) begin errors++; $display("FAIL glitch_valid: got %0d valid cycles expected 0", vcycles - v0); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_count: got %0d bytes expected 0", obs_q.size()); end
        send_frame(8'h5A, 1'b1, even_par(8'h5A));
        cycles(8);
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL glitch_after_count: got %0d bytes expected 1", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            checks++;
            if (got !== expect_word(8'h5A, 1'b1, even_par(8'h5A)))
                begin errors++; $display("FAIL glitch_after_data: got %h expected %h", got, expect_word(8'h5A, 1'b1, even_par(8'h5A))); end
        end
    endtask

    task automatic test_break;
        logic [9:0] got;
        obs_q.delete();
        send_frame(8'h3C, 1'b0, even_par(8'h3C));
        cycles(40);
        rx_i = 1'b1;
        cycles(200);
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL break_count: got %0d bytes expected 1", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            checks++;
            if (got !== expect_word(8'h3C, 1'b0, even_par(8'h3C)))
                begin errors++; $display("FAIL break_data: got %h expected %h", got, expect_word(8'h3C, 1'b0, even_par(8'h3C))); end
        end
    endtask

    task automatic test_overrun;
        int o0;
        logic [9:0] got;
        obs_q.delete();
        ready_i = 1'b0;
        o0 = ovr_cycles;
        send_frame(8'h01, 1'b1, even_par(8'h01));
        send_frame(8'h02, 1'b1, even_par(8'h02));
        cycles(4);
        checks += 4;
        if (ovr_cycles - o0 != 1) begin errors++; $display("FAIL ovr_pulse: got %0d cycles expected 1", ovr_cycles - o0); end
        if (data_o !== 8'h01) begin errors++; $display("FAIL ovr_hold: got %h expected 01", data_o); end
        if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", valid_o); end
        if (obs_q.size() != 0) begin errors++; $display("FAIL ovr_early: got %0d bytes expected 0", obs_q.size()); end
        ready_i = 1'b1;
        cycles(1);
        checks += 2;
        if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", valid_o); end
        if (obs_q.size() != 1) begin errors++; $display("FAIL ovr_accept_count: got %0d bytes expected 1", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            checks++;
            if (got[7:0] !== 8'h01) begin errors++; $display("FAIL ovr_accept_data: got %h expected 01", got[7:0]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [9:0] got;
        obs_q.delete();
        ready_i = 1'b0;
        send_frame(8'h42, 1'b0, even_par(8'h42));
        rx_i = 1'b1;
        cycles(20);
        rx_i = 1'b0;
        cycles(CPB);
        rx_i = 1'b1;
        cycles(4 * CPB + CPB / 2);
        arstn_i = 1'b0;
        #1;
        checks += 4;
        if (data_o !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %h expected 00", data_o); end
        if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", valid_o); end
        if (frame_err_o !== 1'b0) begin errors++; $display("FAIL mid_reset_fe: got %b expected 0", frame_err_o); end
        if (overrun_o !== 1'b0) begin errors++; $display("FAIL mid_reset_ovr: got %b expected 0", overrun_o); end
        cycles(3);
        arstn_i = 1'b1;
        ready_i = 1'b1;
        cycles(4);
        send_frame(8'h81, 1'b1, even_par(8'h81));
        cycles(8);
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL mid_after_count: got %0d bytes expected 1", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            checks++;
            if (got !== expect_word(8'h81, 1'b1, even_par(8'h81)))
                begin errors++; $display("FAIL mid_after_data: got %h expected %h", got, expect_word(8'h81, 1'b1, even_par(8'h81))); end
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        logic [9:0] got;
        obs_q.delete();
        ready_i = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        cycles(8);
        send_frame(8'h07, 1'b1, 1'b1);
        cycles(8);
        checks++;
        if (obs_q.size() != 2) begin errors++; $display("FAIL parity_count: got %0d bytes expected 2", obs_q.size()); end
        else begin
            got = obs_q.pop_front();
            checks += 2;
            if (got !== 10'h207) begin errors++; $display("FAIL parity_bad: got %h expected 207", got); end
            got = obs_q.pop_front();
            if (got !== 10'h007) begin errors++; $display("FAIL parity_good: got %h expected 007", got); end
        end
    endtask
`endif

    task automatic test_random;
        logic [9:0] exp_q[$];
        logic [9:0] got;
        logic [7:0] d;
        logic       s;
        logic       p;
        obs_q.delete();
        ready_i = 1'b1;
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            s = $urandom_range(0, 3) != 0;
            p = 1'($urandom_range(0, 1));
            exp_q.push_back(expect_word(d, s, p));
            send_frame(d, s, p);
            rx_i = 1'b1;
            cycles($urandom_range(2, 20));
        end
        cycles(8);
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d bytes expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            got = obs_q[i];
            checks++;
            if (got !== exp_q[i]) begin errors++; $display("FAIL rand_byte%0d: got %h expected %h", i, got, exp_q[i]); end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_glitch;
        test_break;
        test_overrun;
        test_reset_mid;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
